// File: rtl/lv_pwm_intb_decode.sv
// lv_pwm_intb_decode: compares the HV PWM-return wave against the delayed gate wave,
// decodes INTB0/INTB1 slot frames, flags malformed frames and a missing periodic refresh.
module lv_pwm_intb_decode #(
  parameter int SYNC_STG = 2,
  parameter int LOOP_DLY = 3,
  parameter int EXT_CYC  = 8,
  parameter int TOL      = 1,
  parameter int WDG_TO_W = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_pwm_gwave,
  input  logic                i_pwm_intb_n,
  input  logic                i_wdg_en,
  input  logic [WDG_TO_W-1:0] i_wdg_to_cyc,
  output logic                o_intb_n,
  output logic                o_intb_vld,
  output logic                o_frame_err,
  output logic                o_wdg_tmo
);
  localparam int CW = $clog2(EXT_CYC + TOL + 2);
  localparam logic [CW-1:0] C_LO  = CW'(EXT_CYC - TOL);
  localparam logic [CW-1:0] C_HI  = CW'(EXT_CYC + TOL);
  localparam logic [CW-1:0] C_SAT = CW'(EXT_CYC + TOL + 1);
  localparam logic [CW-1:0] C_RUN = CW'(EXT_CYC - 1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  typedef enum logic [2:0] {IDLE, SEG0, SEG1, SEG2, RECOV} state_t;
  state_t              r_state, w_state_nx;
  logic [SYNC_STG-1:0] r_sync;
  logic [LOOP_DLY-1:0] r_dly;
  logic [CW-1:0]       r_cnt, w_cnt_nx, w_inc;
  logic                r_lvl, w_lvl_nx;
  logic                w_rx, w_exp, w_mis, w_in_win, w_over;
  logic                w_dec0, w_dec1, w_err, w_wdg_on;
  logic [WDG_TO_W-1:0] r_wdg;
  assign w_rx     = r_sync[SYNC_STG-1];
  assign w_exp    = r_dly[LOOP_DLY-1];
  assign w_mis    = w_rx ^ w_exp;
  assign w_in_win = (r_cnt >= C_LO) && (r_cnt <= C_HI);
  assign w_over   = r_cnt > C_HI;
  assign w_inc    = (r_cnt == C_SAT) ? r_cnt : r_cnt + C_ONE;
  assign w_wdg_on = i_wdg_en && (i_wdg_to_cyc != '0);
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_lvl_nx   = r_lvl;
    w_dec0     = 1'b0;
    w_dec1     = 1'b0;
    w_err      = 1'b0;
    case (r_state)
      IDLE: if (w_mis) begin
        w_lvl_nx   = w_exp;
        w_cnt_nx   = C_ONE;
        w_state_nx = SEG0;
      end
      SEG0: if (w_over) begin
        w_err      = 1'b1;
        w_cnt_nx   = '0;
        w_state_nx = RECOV;
      end else if (w_mis) w_cnt_nx = w_inc;
      else if (!w_in_win) w_state_nx = IDLE;
      else begin
        w_cnt_nx   = C_ONE;
        w_state_nx = SEG1;
      end
      // Locked and trailing slots track the latched level only; exp may toggle here.
      SEG1: if (w_rx == r_lvl) begin
        if (r_cnt == C_HI) begin
          w_dec0     = 1'b1;
          w_state_nx = IDLE;
        end else w_cnt_nx = w_inc;
      end else if (w_in_win) begin
        w_cnt_nx   = C_ONE;
        w_state_nx = SEG2;
      end else begin
        w_err      = 1'b1;
        w_cnt_nx   = '0;
        w_state_nx = RECOV;
      end
      SEG2: if (w_over) begin
        w_err      = 1'b1;
        w_cnt_nx   = '0;
        w_state_nx = RECOV;
      end else if (w_rx != r_lvl) w_cnt_nx = w_inc;
      else if (w_in_win) begin
        w_dec1     = 1'b1;
        w_state_nx = IDLE;
      end else begin
        w_err      = 1'b1;
        w_cnt_nx   = '0;
        w_state_nx = RECOV;
      end
      RECOV: if (w_mis) w_cnt_nx = '0;
      else if (r_cnt == C_RUN) w_state_nx = IDLE;
      else w_cnt_nx = w_inc;
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync      <= '0;
      r_dly       <= '0;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_lvl       <= 1'b0;
      o_intb_n    <= 1'b1;
      o_intb_vld  <= 1'b0;
      o_frame_err <= 1'b0;
      r_wdg       <= '0;
      o_wdg_tmo   <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STG-2:0], i_pwm_intb_n};
      r_dly       <= {r_dly[LOOP_DLY-2:0], i_pwm_gwave};
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_lvl       <= w_lvl_nx;
      o_intb_n    <= w_dec0 ? 1'b0 : w_dec1 ? 1'b1 : o_intb_n;
      o_intb_vld  <= w_dec0 | w_dec1;
      o_frame_err <= w_err;
      r_wdg       <= (!w_wdg_on || o_intb_vld) ? '0 : o_wdg_tmo ? r_wdg : r_wdg + WDG_TO_W'(1);
      o_wdg_tmo   <= (!i_wdg_en || o_intb_vld) ? 1'b0 :
                     (w_wdg_on && !o_wdg_tmo && r_wdg == i_wdg_to_cyc - WDG_TO_W'(1)) ? 1'b1 : o_wdg_tmo;
    end
  end
endmodule

// File: tb/tb_lv_pwm_intb_decode.sv
// tb_lv_pwm_intb_decode: directed frames with a queue scoreboard; a negedge monitor
// pops one expected event per o_intb_vld / o_frame_err pulse.
module tb_lv_pwm_intb_decode;
  logic        clk, rst_n, gwave, pin, wdg_en;
  logic [15:0] wdg_to;
  logic        intb_n, vld, err, tmo;
  typedef struct packed {logic e; logic l;} ev_t;
  ev_t q[$];
  int tests = 0, fails = 0;
  lv_pwm_intb_decode dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pwm_gwave(gwave), .i_pwm_intb_n(pin),
    .i_wdg_en(wdg_en), .i_wdg_to_cyc(wdg_to),
    .o_intb_n(intb_n), .o_intb_vld(vld), .o_frame_err(err), .o_wdg_tmo(tmo)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    #200000;
    $display("FAIL tb_timeout: got no end want end");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask
  task automatic expect_ev(input logic e, input logic l);
    q.push_back({e, l});
  endtask
  task automatic cyc(input logic g, input logic p);
    gwave = g;
    pin   = p;
    @(negedge clk);
  endtask
  task automatic frame(input logic g, input int a, input int b, input int c, input int tail);
    repeat (6) cyc(g, g);
    repeat (a) cyc(g, ~g);
    repeat (b) cyc(g, g);
    repeat (c) cyc(g, ~g);
    repeat (tail) cyc(g, g);
  endtask
  always @(negedge clk) begin
    if (rst_n && (vld || err)) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: got vld=%0b err=%0b want none", vld, err);
      end else begin
        ev_t ev;
        ev = q.pop_front();
        chk("event_is_err", {31'd0, err}, {31'd0, ev.e});
        if (!ev.e) chk("event_intb_n", {31'd0, intb_n}, {31'd0, ev.l});
      end
    end
  end
  initial begin
    logic prev;
    rst_n = 1'b0; gwave = 1'b0; pin = 1'b0; wdg_en = 1'b0; wdg_to = '0;
    repeat (3) @(negedge clk);
    chk("rst_intb_n", {31'd0, intb_n}, 1);
    chk("rst_vld", {31'd0, vld}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_tmo", {31'd0, tmo}, 0);
    rst_n = 1'b1;
    repeat (10) cyc(0, 0);
    prev = 1'b0;
    for (int i = 0; i < 120; i++) begin
      logic g;
      g = (i % 40) < 20;
      cyc(g, prev);
      prev = g;
    end
    repeat (10) cyc(0, 0);
    chk("echo_intb_n", {31'd0, intb_n}, 1);
    expect_ev(0, 0); frame(0, 8, 0, 0, 30);
    chk("intb0_level", {31'd0, intb_n}, 0);
    expect_ev(0, 1); frame(0, 8, 8, 8, 30);
    expect_ev(0, 1); frame(1, 7, 7, 7, 30);
    expect_ev(0, 1); frame(0, 9, 9, 9, 30);
    chk("intb1_level", {31'd0, intb_n}, 1);
    frame(0, 3, 0, 0, 20);
    frame(0, 6, 0, 0, 20);
    expect_ev(1, 0); frame(0, 10, 0, 0, 30);
    expect_ev(1, 0); frame(0, 12, 0, 0, 30);
    expect_ev(0, 0); frame(0, 8, 0, 0, 30);
    expect_ev(1, 0); frame(0, 8, 5, 3, 30);
    chk("err_keeps_intb_n", {31'd0, intb_n}, 0);
    wdg_to = 16'd100;
    wdg_en = 1'b1;
    repeat (99) cyc(0, 0);
    chk("wdg_before_thr", {31'd0, tmo}, 0);
    cyc(0, 0);
    chk("wdg_at_thr", {31'd0, tmo}, 1);
    repeat (20) cyc(0, 0);
    chk("wdg_sticky", {31'd0, tmo}, 1);
    expect_ev(0, 1); frame(0, 8, 8, 8, 30);
    chk("wdg_cleared", {31'd0, tmo}, 0);
    wdg_en = 1'b0;
    expect_ev(0, 0); frame(0, 8, 0, 0, 30);
    repeat (6) cyc(0, 0);
    repeat (8) cyc(0, 1);
    repeat (8) cyc(0, 0);
    repeat (4) cyc(0, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_intb_n", {31'd0, intb_n}, 1);
    chk("midrst_vld", {31'd0, vld}, 0);
    @(negedge clk);
    repeat (3) cyc(0, 0);
    rst_n = 1'b1;
    repeat (10) cyc(0, 0);
    expect_ev(0, 0); frame(0, 8, 0, 0, 30);
    repeat (10) cyc(0, 0);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
